instr_stream_sequencer: RTL and testbench

//  Parametrised program store and instruction issuer feeding the CPU decoder.

---
 rtl/instr_stream_sequencer.sv | 136 +++++++++++++
 tb/tb_instr_stream_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_sequencer.sv
// Program store plus slice-serial instruction issuer: words pc=0..len-1 leave MS slice
// first, one slice per cycle, each word occupying a fixed SLOT_CYCLES-cycle issue slot.
module instr_stream_sequencer #(
    parameter int INSTR_W     = 16,
    parameter int SLICE_W     = 8,
    parameter int DEPTH       = 16,
    parameter int SLOT_CYCLES = 8,
    parameter bit LOOP        = 1'b0,
    parameter     INIT_FILE   = "",
    localparam int SLICES     = INSTR_W / SLICE_W,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SIW        = $clog2(SLICES) + 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [AW:0]        prog_len,
    input  logic               stall,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    output logic               out_valid,
    output logic [SLICE_W-1:0] out_slice,
    output logic [SIW-1:0]     slice_idx,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               done
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);
    localparam logic [CW-1:0] LAST_CYC   = CW'(SLOT_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_L    = (AW + 1)'(DEPTH);
    localparam bit            HAS_WAIT   = (SLOT_CYCLES > SLICES);

    typedef enum logic [1:0] {IDLE, EMIT, WAIT, DONE} state_t;

    state_t               state;
    logic [INSTR_W-1:0]   mem [DEPTH];
    logic [INSTR_W-1:0]   shreg;
    logic [CW-1:0]        slot_cnt;
    logic [AW-1:0]        last_pc;
    logic [AW-1:0]        pc_inc;
    logic [AW:0]          len_clamped;
    logic                 valid_reg;
    logic                 wr_in_range;
    logic                 slot_end;

    // Only a non power-of-two depth leaves addresses that must be dropped.
    if (DEPTH == (1 << AW)) begin : g_full
        assign wr_in_range = 1'b1;
    end else begin : g_part
        assign wr_in_range = (wr_addr < AW'(DEPTH));
    end

    // NOTE: program memory has no reset; RESET leaves its contents alone.
    always_ff @(posedge CLK) begin
        if (wr_en && wr_in_range) mem[wr_addr] <= wr_data;
    end

    assign pc_inc      = pc + 1'b1;
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign out_valid   = valid_reg & ~stall;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        slot_end = 1'b0;
        if (state == EMIT && !HAS_WAIT) slot_end = (slot_cnt == LAST_SLICE);
        else if (state == WAIT)         slot_end = (slot_cnt == LAST_CYC);
    end

    // NOTE: state uses non-blocking assignments; the end-of-slot block relies on a later
    // assignment in the same block overriding the per-state defaults above it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            pc        <= '0;
            last_pc   <= '0;
            slot_cnt  <= '0;
            shreg     <= '0;
            out_slice <= '0;
            slice_idx <= '0;
            valid_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (!stall) begin
            done      <= 1'b0;
            valid_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && prog_len != '0) begin
                        state    <= EMIT;
                        pc       <= '0;
                        last_pc  <= AW'(len_clamped - 1'b1);
                        slot_cnt <= '0;
                        shreg    <= mem[0];
                        busy     <= 1'b1;
                    end
                end
                EMIT: begin
                    valid_reg <= 1'b1;
                    out_slice <= shreg[INSTR_W-1 -: SLICE_W];
                    slice_idx <= SIW'(slot_cnt);
                    shreg     <= shreg << SLICE_W;
                    slot_cnt  <= slot_cnt + 1'b1;
                    if (HAS_WAIT && slot_cnt == LAST_SLICE) state <= WAIT;
                end
                WAIT: slot_cnt <= slot_cnt + 1'b1;
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    pc    <= '0;
                end
                default: state <= IDLE;
            endcase

            // The next word is latched at slot start, so later writes only hit later passes.
            if (slot_end) begin
                slot_cnt <= '0;
                if (pc != last_pc) begin
                    pc    <= pc_inc;
                    shreg <= mem[pc_inc];
                    state <= EMIT;
                end else if (LOOP) begin
                    pc    <= '0;
                    shreg <= mem[0];
                    state <= EMIT;
                end else begin
                    state <= DONE;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_sequencer.sv
// Bench for instr_stream_sequencer: four parameter variants share stimulus and are checked
// every cycle against a virtual-time model of the issue schedule.
module tb_instr_stream_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  prog_len = '0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;

    logic        ov  [4];
    logic [7:0]  os  [4];
    logic [1:0]  si  [4];
    logic [3:0]  pcs [4];
    logic        bz  [4];
    logic        dn  [4];

    logic [15:0] mm   [4][16];
    logic [15:0] latw [4][256];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    instr_stream_sequencer #(.DEPTH(16), .SLOT_CYCLES(8), .LOOP(1'b0)) u_d0 (
        .CLK(CLK), .RESET(RESET), .start(start), .prog_len(prog_len), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(ov[0]),
        .out_slice(os[0]), .slice_idx(si[0]), .pc(pcs[0]), .busy(bz[0]), .done(dn[0]));
    instr_stream_sequencer #(.DEPTH(16), .SLOT_CYCLES(8), .LOOP(1'b1)) u_d1 (
        .CLK(CLK), .RESET(RESET), .start(start), .prog_len(prog_len), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(ov[1]),
        .out_slice(os[1]), .slice_idx(si[1]), .pc(pcs[1]), .busy(bz[1]), .done(dn[1]));
    instr_stream_sequencer #(.DEPTH(16), .SLOT_CYCLES(2), .LOOP(1'b0)) u_d2 (
        .CLK(CLK), .RESET(RESET), .start(start), .prog_len(prog_len), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(ov[2]),
        .out_slice(os[2]), .slice_idx(si[2]), .pc(pcs[2]), .busy(bz[2]), .done(dn[2]));
    instr_stream_sequencer #(.DEPTH(12), .SLOT_CYCLES(8), .LOOP(1'b0)) u_d3 (
        .CLK(CLK), .RESET(RESET), .start(start), .prog_len(prog_len), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(ov[3]),
        .out_slice(os[3]), .slice_idx(si[3]), .pc(pcs[3]), .busy(bz[3]), .done(dn[3]));

    function automatic int slot_of(input int d);
        return (d == 2) ? 2 : 8;
    endfunction

    function automatic bit loop_of(input int d);
        return (d == 1);
    endfunction

    function automatic int depth_of(input int d);
        return (d == 3) ? 12 : 16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [3:0] a, input logic [15:0] w);
        for (int d = 0; d < 4; d++)
            if (int'(a) < depth_of(d)) mm[d][a] = w;
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [15:0] w);
        wr_en = 1'b1; wr_addr = a; wr_data = w;
        @(posedge CLK);
        model_write(a, w);
        #1 wr_en = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0; stall = 1'b0; wr_en = 1'b0; RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s d%0d out_valid", tag, d), ov[d], 0);
            check($sformatf("%s d%0d out_slice", tag, d), os[d], 0);
            check($sformatf("%s d%0d slice_idx", tag, d), si[d], 0);
            check($sformatf("%s d%0d pc", tag, d), pcs[d], 0);
            check($sformatf("%s d%0d busy", tag, d), bz[d], 0);
            check($sformatf("%s d%0d done", tag, d), dn[d], 0);
        end
    endtask

    // v counts unstalled edges since start: slot s begins at v = s*SLOT and its slices are
    // visible at v = s*SLOT+1 .. s*SLOT+2; a non-loop run pulses done at v = L*SLOT+1.
    task automatic check_model(input int d, input int c, input int v, input logic st, input int L);
        int sl, rs, off;
        logic ev, eb, ed;
        logic [15:0] w;
        logic [7:0] es;
        string tag;
        sl  = slot_of(d);
        tag = $sformatf("d%0d c%0d", d, c);
        rs  = (v >= 1) ? (v - 1) / sl : 0;
        off = (v >= 1) ? (v - 1) % sl : 0;
        if (L == 0) begin
            ev = 1'b0; eb = 1'b0; ed = 1'b0;
        end else begin
            ev = !st && v >= 1 && off < 2 && (loop_of(d) || rs < L);
            eb = loop_of(d) || v < L * sl;
            ed = !loop_of(d) && v == L * sl + 1;
        end
        check({tag, " out_valid"}, ov[d], ev);
        check({tag, " busy"}, bz[d], eb);
        check({tag, " done"}, dn[d], ed);
        if (ev) begin
            w  = latw[d][rs];
            es = (off == 0) ? w[15:8] : w[7:0];
            check({tag, " out_slice"}, os[d], es);
            check({tag, " slice_idx"}, si[d], off);
        end
        if (eb) check({tag, " pc"}, pcs[d], (v / sl) % L);
    endtask

    task automatic run(input int len_in, input int ncyc, input int stall_pct,
                       input int st_from, input int st_len,
                       input int wcyc, input logic [3:0] wa, input logic [15:0] wd);
        int v;
        int eff [4];
        int sidx;
        logic st;
        do_reset();
        start = 1'b1; prog_len = 5'(len_in);
        @(posedge CLK);
        for (int d = 0; d < 4; d++) begin
            eff[d] = (len_in < depth_of(d)) ? len_in : depth_of(d);
            if (eff[d] != 0) latw[d][0] = mm[d][0];
        end
        #1 start = 1'b0;
        v = 0;
        for (int c = 0; c < ncyc; c++) begin
            st = ((c >= st_from) && (c < st_from + st_len)) ||
                 (int'($urandom_range(99)) < stall_pct);
            stall = st;
            wr_en = (c == wcyc); wr_addr = wa; wr_data = wd;
            @(negedge CLK);
            for (int d = 0; d < 4; d++) check_model(d, c, v, st, eff[d]);
            @(posedge CLK);
            if (!st) begin
                v++;
                for (int d = 0; d < 4; d++) begin
                    sidx = v / slot_of(d);
                    if (eff[d] != 0 && v % slot_of(d) == 0 && sidx < 256 &&
                        (loop_of(d) || sidx < eff[d]))
                        latw[d][sidx] = mm[d][sidx % eff[d]];
                end
            end
            if (wr_en) model_write(wa, wd);
            #1;
        end
        stall = 1'b0; wr_en = 1'b0;
    endtask

    typedef struct {
        int         cyc;
        logic       v;
        logic [7:0] s;
        logic [1:0] idx;
        logic       b;
        logic       d;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int cyc;

        tbl[0]  = '{0,  1'b0, 8'h00, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{1,  1'b1, 8'h18, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{2,  1'b1, 8'h1C, 2'd1, 1'b1, 1'b0};
        tbl[3]  = '{3,  1'b0, 8'h00, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{8,  1'b0, 8'h00, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{9,  1'b1, 8'h38, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{10, 1'b1, 8'h36, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{17, 1'b1, 8'h58, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{18, 1'b1, 8'h5B, 2'd1, 1'b1, 1'b0};
        tbl[9]  = '{25, 1'b1, 8'h60, 2'd0, 1'b1, 1'b0};
        tbl[10] = '{26, 1'b1, 8'h00, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{27, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0};
        tbl[12] = '{31, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0};
        tbl[13] = '{32, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[14] = '{33, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
        tbl[15] = '{34, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK);
        #1 RESET = 1'b0;

        for (int a = 0; a < 16; a++) wr_word(4'(a), 16'($urandom));
        wr_word(4'd0, 16'h181C);
        wr_word(4'd1, 16'h3836);
        wr_word(4'd2, 16'h585B);
        wr_word(4'd3, 16'h6000);

        // Reference issue timeline for len=4 on the SLOT=8 non-loop variant
        do_reset();
        start = 1'b1; prog_len = 5'd4;
        @(posedge CLK);
        #1 start = 1'b0;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            while (cyc < tbl[i].cyc) begin
                @(posedge CLK);
                #1 cyc++;
            end
            @(negedge CLK);
            check($sformatf("tbl c%0d out_valid", cyc), ov[0], tbl[i].v);
            check($sformatf("tbl c%0d busy", cyc), bz[0], tbl[i].b);
            check($sformatf("tbl c%0d done", cyc), dn[0], tbl[i].d);
            if (tbl[i].v) begin
                check($sformatf("tbl c%0d out_slice", cyc), os[0], tbl[i].s);
                check($sformatf("tbl c%0d slice_idx", cyc), si[0], tbl[i].idx);
            end
        end

        // Loop mode, stall window, zero length, oversize length
        run(2, 40, 0, 0, 0, -1, 4'd0, 16'h0);
        run(2, 30, 0, 2, 3, -1, 4'd0, 16'h0);
        run(0, 10, 0, 0, 0, -1, 4'd0, 16'h0);
        run(20, 135, 0, 0, 0, -1, 4'd0, 16'h0);

        // Reset in the middle of the first slot's idle tail
        do_reset();
        start = 1'b1; prog_len = 5'd3;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_all_zero("midrun reset");
        run(3, 40, 0, 0, 0, -1, 4'd0, 16'h0);

        // Write to the active word mid-slot, and a write on the latching edge
        run(2, 40, 0, 0, 0, 1, 4'd0, 16'hA5C3);
        run(2, 40, 0, 0, 0, 7, 4'd1, 16'h7E81);

        // Out-of-range addresses on the 12-deep variant must not disturb words 0..11
        for (int a = 12; a < 16; a++) wr_word(4'(a), 16'($urandom));
        run(20, 110, 0, 0, 0, -1, 4'd0, 16'h0);

        // Randomised programs, lengths, stalls and mid-run writes
        for (int it = 0; it < 6; it++) begin
            repeat (4) wr_word(4'($urandom_range(0, 15)), 16'($urandom));
            run(int'($urandom_range(0, 20)), 200, 20, 0, 0,
                int'($urandom_range(0, 150)), 4'($urandom_range(0, 15)), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
